// File: rtl/dma_xfer.sv
// dma_xfer: two-stage read/write byte mover behind the DMA address generator.
// Optional transfer counter enabled by defining DMA_XFER_STATS_EN.
module dma_xfer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        dma_en_i,
  input  logic        dma_dir_i,
  input  logic        dma_hold_i,
  input  logic [15:0] cbus_addr_i,
  input  logic [12:0] vbus_addr_i,
  input  logic [7:0]  cbus_din_i,
  input  logic [7:0]  vbus_din_i,
  output logic [15:0] cbus_a_o,
  output logic        cbus_rd_o,
  output logic        cbus_wr_o,
  output logic [7:0]  cbus_dout_o,
  output logic [12:0] vbus_a_o,
  output logic        vbus_rd_o,
  output logic        vbus_wr_o,
  output logic [7:0]  vbus_dout_o,
  output logic        cpu_halt_o,
  output logic [15:0] xfer_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic        wr_v_q, wr_v_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] ca_q;
  logic [12:0] va_q;
  logic [7:0]  cdo_q;
  logic [7:0]  vdo_q;
  logic        active;
  logic        rd_go;
  logic        wr_go;

  // Strobes, muxed addresses/data and halt; reset kills any pending write.
  always_comb begin
    active = ce_i & ~reset_i;
    rd_go  = active & (state_q == S_RUN)
           & dma_en_i & ~dma_hold_i;
    wr_go  = active & wr_v_q
           & (state_q != S_IDLE);

    cbus_rd_o = rd_go & ~dir_q;
    vbus_rd_o = rd_go & dir_q;
    vbus_wr_o = wr_go & ~dir_q;
    cbus_wr_o = wr_go & dir_q;

    cbus_a_o = ca_q;
    if (cbus_wr_o)
      cbus_a_o = dst_q;
    else if (cbus_rd_o)
      cbus_a_o = cbus_addr_i;

    vbus_a_o = va_q;
    if (vbus_wr_o)
      vbus_a_o = dst_q[12:0];
    else if (vbus_rd_o)
      vbus_a_o = vbus_addr_i;

    cbus_dout_o = cbus_wr_o ? vbus_din_i : cdo_q;
    vbus_dout_o = vbus_wr_o ? cbus_din_i : vdo_q;

    cpu_halt_o = dma_en_i | (state_q != S_IDLE);
  end

  // Next state, direction latch and write-pending pipeline register.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    wr_v_d  = wr_v_q;
    dst_d   = dst_q;

    if (wr_go)
      wr_v_d = 1'b0;
    if (rd_go) begin
      wr_v_d = 1'b1;
      dst_d  = dir_q ? cbus_addr_i
                     : {3'b000, vbus_addr_i};
    end

    if (ce_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (dma_en_i) begin
            state_d = S_RUN;
            dir_d   = dma_dir_i;
          end
        end
        S_RUN: begin
          if (!dma_en_i)
            state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (dma_en_i) begin
            state_d = S_RUN;
            dir_d   = dma_dir_i;
          end else if (!wr_v_d) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and pipeline registers; address/data outputs hold last value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      wr_v_q  <= 1'b0;
      dst_q   <= '0;
      ca_q    <= '0;
      va_q    <= '0;
      cdo_q   <= '0;
      vdo_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wr_v_q  <= wr_v_d;
      dst_q   <= dst_d;
      ca_q    <= cbus_a_o;
      va_q    <= vbus_a_o;
      cdo_q   <= cbus_dout_o;
      vdo_q   <= vbus_dout_o;
    end
  end

`ifdef DMA_XFER_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic        start;

  // Completed-write counter, cleared when a new transfer starts from idle.
  always_comb begin
    start = ce_i & dma_en_i & (state_q == S_IDLE);
    cnt_d = cnt_q;
    if (start)
      cnt_d = '0;
    else if (wr_go)
      cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign xfer_count_o = cnt_q;
`else
  assign xfer_count_o = '0;
`endif

endmodule

// File: tb/tb_dma_xfer.sv
// tb_dma_xfer: vector table plus scoreboarded transfers for dma_xfer.
// Memory models stand in for the CPU bus and VRAM.
module tb_dma_xfer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        en;
  logic        dir;
  logic        hold;
  logic [15:0] caddr;
  logic [12:0] vaddr;
  logic [7:0]  cdin;
  logic [7:0]  vdin;
  logic [15:0] ca;
  logic        crd, cwr;
  logic [7:0]  cdo;
  logic [12:0] va;
  logic        vrd, vwr;
  logic [7:0]  vdo;
  logic        halt;
  logic [15:0] cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int cediv = 1;
  int ci    = 0;
  int nrd   = 0;

  logic [7:0] cmem [0:65535];
  logic [7:0] vmem [0:8191];

  typedef struct packed {
    logic        wbus;
    logic [15:0] a;
    logic [7:0]  d;
    logic [31:0] ci;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        rst, ce, en, dir, hold;
    logic [15:0] ca;
    logic [12:0] va;
    logic [3:0]  stb;
    logic        halt;
    logic [15:0] eca;
    logic [12:0] eva;
  } vec_t;
  vec_t tbl[10];

  dma_xfer dut (
    .clk_i(clk), .reset_i(rst), .ce_i(ce),
    .dma_en_i(en), .dma_dir_i(dir),
    .dma_hold_i(hold),
    .cbus_addr_i(caddr), .vbus_addr_i(vaddr),
    .cbus_din_i(cdin), .vbus_din_i(vdin),
    .cbus_a_o(ca), .cbus_rd_o(crd),
    .cbus_wr_o(cwr), .cbus_dout_o(cdo),
    .vbus_a_o(va), .vbus_rd_o(vrd),
    .vbus_wr_o(vwr), .vbus_dout_o(vdo),
    .cpu_halt_o(halt), .xfer_count_o(cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memories: read data appears after the ce edge.
  always @(posedge clk) begin
    if (ce) begin
      if (crd) cdin <= cmem[ca];
      if (vrd) vdin <= vmem[va];
      if (cwr) cmem[ca] <= cdo;
      if (vwr) vmem[va] <= vdo;
    end
  end

  // Scoreboard: reads push the expected write, writes pop and compare.
  always @(negedge clk) begin
    sb_t it;
    if (!ce) begin
      n_chk++;
      if (crd | cwr | vrd | vwr) begin
        n_err++;
        $display("FAIL gate: strobes=%b on ce=0, required 0000",
                 {crd, cwr, vrd, vwr});
      end
    end else begin
      if (cwr | vwr) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stray_wr: write c=%b v=%b with nothing pending",
                   cwr, vwr);
        end else begin
          it = sb.pop_front();
          if (cwr !== it.wbus || vwr !== !it.wbus ||
              (it.wbus ? ca : {3'b000, va}) !== it.a ||
              (it.wbus ? cdo : vdo) !== it.d ||
              32'(ci) !== it.ci + 1) begin
            n_err++;
            $display("FAIL wr: cwr=%b a=%h d=%h ci=%0d, required cwr=%b a=%h d=%h ci=%0d",
                     cwr, it.wbus ? ca : {3'b000, va},
                     it.wbus ? cdo : vdo, ci,
                     it.wbus, it.a, it.d, it.ci + 1);
          end
        end
      end
      if (crd) begin
        sb.push_back({1'b0, {3'b000, vaddr}, cmem[caddr], 32'(ci)});
        nrd++;
      end
      if (vrd) begin
        sb.push_back({1'b1, caddr, vmem[vaddr], 32'(ci)});
        nrd++;
      end
      ci++;
    end
  end

  function automatic vec_t mk(
    input logic r, c, e, d, h,
    input logic [15:0] a, input logic [12:0] b,
    input logic [3:0] s, input logic hl,
    input logic [15:0] ea, input logic [12:0] eb);
    vec_t v;
    v.rst = r; v.ce = c; v.en = e; v.dir = d; v.hold = h;
    v.ca = a; v.va = b; v.stb = s; v.halt = hl;
    v.eca = ea; v.eva = eb;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ce = (cyc % cediv) == 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Behaves like the address generator: advances only on non-hold ce cycles.
  task automatic xfer(input bit d, input logic [15:0] cb,
                      input logic [12:0] vb, input int n,
                      input int hold_at, input bit tog);
    bit c;
    bit held;
    int i;
    int k;
    int r0;
    r0 = nrd;
    en = 1'b1; dir = d; caddr = cb; vaddr = vb; hold = 1'b0;
    do begin c = ce; tick(); end while (!c);
    i = 0; held = 1'b0;
    while (i < n) begin
      caddr = cb + 16'(i);
      vaddr = vb + 13'(i);
      hold  = (i == hold_at) && !held;
      if (tog) dir = ~dir;
      c = ce;
      tick();
      if (c) begin
        if (hold) held = 1'b1;
        else i++;
      end
    end
    en = 1'b0; hold = 1'b0;
    k = 0;
    while (halt === 1'b1 && k < 60) begin tick(); k++; end
    chk("halt_drop", 32'(halt), 32'h0);
    if (cediv == 1) chk("halt_len", 32'(k), 32'd2);
    chk("rd_count", 32'(nrd - r0), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) cmem[i] = 8'h00;
    for (int i = 0; i < 8192; i++) vmem[i] = 8'h00;
    cmem[16'h1000] = 8'hAA; cmem[16'h1001] = 8'hBB;
    cmem[16'h1002] = 8'hCC; cmem[16'h1003] = 8'hDD;
    vmem[13'h1FFE] = 8'h11; vmem[13'h1FFF] = 8'h22;
    vmem[13'h0000] = 8'h33;
    cmem[16'h3000] = 8'h44; cmem[16'h3001] = 8'h55;
    cmem[16'h3002] = 8'h66; cmem[16'h3003] = 8'h77;
    vmem[13'h0500] = 8'h5A;
    for (int i = 0; i < 16; i++) cmem[16'h4000 + 16'(i)] = 8'h80 + 8'(i);

    tbl[0] = mk(1,1,0,0,0,16'h0000,13'h000,4'b0000,0,16'h0000,13'h000);
    tbl[1] = mk(0,1,1,0,0,16'h1000,13'h200,4'b0000,1,16'h0000,13'h000);
    tbl[2] = mk(0,1,1,0,0,16'h1000,13'h200,4'b1000,1,16'h1000,13'h000);
    tbl[3] = mk(0,1,1,0,0,16'h1001,13'h201,4'b1001,1,16'h1001,13'h200);
    tbl[4] = mk(0,0,1,0,0,16'h1002,13'h202,4'b0000,1,16'h1001,13'h200);
    tbl[5] = mk(0,1,1,0,0,16'h1002,13'h202,4'b1001,1,16'h1002,13'h201);
    tbl[6] = mk(0,1,1,0,0,16'h1003,13'h203,4'b1001,1,16'h1003,13'h202);
    tbl[7] = mk(0,1,0,0,0,16'h1003,13'h203,4'b0001,1,16'h1003,13'h203);
    tbl[8] = mk(0,1,0,0,0,16'h1003,13'h203,4'b0000,1,16'h1003,13'h203);
    tbl[9] = mk(0,1,0,0,0,16'h1003,13'h203,4'b0000,0,16'h1003,13'h203);

    rst = 1'b1; ce = 1'b1; en = 1'b0; dir = 1'b0; hold = 1'b0;
    caddr = '0; vaddr = '0;
    repeat (2) @(posedge clk);
    #1;

    // CPU -> VRAM, 4 bytes, one ce=0 bubble, cycle by cycle.
    foreach (tbl[r]) begin
      rst = tbl[r].rst; ce = tbl[r].ce; en = tbl[r].en;
      dir = tbl[r].dir; hold = tbl[r].hold;
      caddr = tbl[r].ca; vaddr = tbl[r].va;
      #1;
      n_chk++;
      if ({crd, cwr, vrd, vwr} !== tbl[r].stb || halt !== tbl[r].halt ||
          ca !== tbl[r].eca || va !== tbl[r].eva) begin
        n_err++;
        $display("FAIL vec%0d: stb=%b halt=%b ca=%h va=%h, required stb=%b halt=%b ca=%h va=%h",
                 r, {crd, cwr, vrd, vwr}, halt, ca, va,
                 tbl[r].stb, tbl[r].halt, tbl[r].eca, tbl[r].eva);
      end
      @(posedge clk);
      #1;
    end
    cyc = 0; ce = 1'b1;
    chk("img1_0", 32'(vmem[13'h200]), 32'hAA);
    chk("img1_3", 32'(vmem[13'h203]), 32'hDD);

    // VRAM -> CPU across the VRAM wrap, dir toggling mid-transfer.
    xfer(1'b1, 16'h2000, 13'h1FFE, 3, -1, 1'b1);
    chk("img2_0", 32'(cmem[16'h2000]), 32'h11);
    chk("img2_1", 32'(cmem[16'h2001]), 32'h22);
    chk("img2_2", 32'(cmem[16'h2002]), 32'h33);

    // Hold on the second read slot.
    xfer(1'b0, 16'h3000, 13'h0300, 4, 1, 1'b0);
    chk("img3_0", 32'(vmem[13'h300]), 32'h44);
    chk("img3_1", 32'(vmem[13'h301]), 32'h55);
    chk("img3_2", 32'(vmem[13'h302]), 32'h66);
    chk("img3_3", 32'(vmem[13'h303]), 32'h77);

    // ce every third clock.
    cediv = 3;
    xfer(1'b0, 16'h1000, 13'h0400, 4, -1, 1'b0);
    cediv = 1; ce = 1'b1;
    chk("img4_0", 32'(vmem[13'h400]), 32'hAA);
    chk("img4_3", 32'(vmem[13'h403]), 32'hDD);

    // Reset while a write is pending.
    en = 1'b1; dir = 1'b0; caddr = 16'h1000; vaddr = 13'h0500;
    tick();
    chk("rst_rd", 32'(crd), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_stb", 32'({crd, cwr, vrd, vwr}), 32'h0);
    chk("rst_halt", 32'(halt), 32'h1);
    tick();
    rst = 1'b0; en = 1'b0;
    #1;
    sb.delete();
    chk("rst_stb2", 32'({crd, cwr, vrd, vwr}), 32'h0);
    chk("rst_halt2", 32'(halt), 32'h0);
    chk("rst_ca", 32'(ca), 32'h0);
    chk("rst_va", 32'(va), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    tick();
    chk("rst_nowr", 32'(vmem[13'h500]), 32'h5A);
    chk("rst_idle", 32'({crd, cwr, vrd, vwr, halt}), 32'h0);

`ifdef DMA_XFER_STATS_EN
    xfer(1'b0, 16'h4000, 13'h0600, 16, -1, 1'b0);
    chk("cnt16", 32'(cnt), 32'd16);
    chk("img5_f", 32'(vmem[13'h60F]), 32'h8F);
    en = 1'b1; dir = 1'b0; caddr = 16'h4000; vaddr = 13'h0700;
    tick();
    chk("cnt_clr", 32'(cnt), 32'd0);
    tick();
    en = 1'b0;
    repeat (3) tick();
    chk("cnt1", 32'(cnt), 32'd1);
    chk("img6", 32'(vmem[13'h700]), 32'h80);
`else
    xfer(1'b0, 16'h4000, 13'h0600, 16, -1, 1'b0);
    chk("cnt_off", 32'(cnt), 32'd0);
    chk("img5_f", 32'(vmem[13'h60F]), 32'h8F);
`endif

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dma_xfer.md
# dma_xfer

Byte mover directly downstream of the Supervision DMA address generator. It consumes the generator's per-cycle source/destination addresses, direction and enable, issues reads on the source bus (CPU bus or VRAM), and writes the returned byte to the destination one ce-cycle later through a two-stage read/write pipeline. It also drives the CPU halt that freezes the 65C02 for the whole transfer, including the final pipeline drain.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; the pipeline advances only on ce cycles
- dma_en  in  1  transfer active, from the address generator
- dma_dir  in  1  0 = CPU bus → VRAM, 1 = VRAM → CPU bus
- dma_hold  in  1  generator stall slot (LCD fetch); addresses do not advance this cycle
- cbus_addr  in  16  current CPU-bus address from the generator
- vbus_addr  in  13  current VRAM address from the generator
- cbus_din  in  8  CPU-bus read data, valid one ce-cycle after the read
- vbus_din  in  8  VRAM read data, valid one ce-cycle after the read
- cbus_a  out  16  CPU-bus address (read or write)
- cbus_rd / cbus_wr  out  1  CPU-bus read / write strobes
- cbus_dout  out  8  CPU-bus write data
- vbus_a  out  13  VRAM address (read or write)
- vbus_rd / vbus_wr  out  1  VRAM read / write strobes
- vbus_dout  out  8  VRAM write data
- cpu_halt  out  1  high while the CPU must not own the bus
- xfer_count  out  16  bytes written since the last transfer start (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on a ce cycle with dma_en=1. dma_dir is latched as dir_q at this point and ignored for the rest of the transfer.
  - RUN → DRAIN on the first ce cycle with dma_en=0.
  - DRAIN → IDLE once no write is pending. DRAIN → RUN if dma_en=1, latching dir_q again.
- Read stage, RUN only, on ce with dma_hold=0:
  - Assert the source rd strobe and drive the source address from the generator input.
  - Capture the destination address into dst_q and set wr_v.
- Write stage, on a ce cycle with wr_v=1:
  - Assert the destination wr strobe at dst_q.
  - Data is the source din: cbus_din when dir_q=0, vbus_din when dir_q=1.
  - Clear wr_v unless a new read issues in the same cycle.
- A read and a write occur on opposite buses in the same cycle, so there is no bus conflict.
- Address outputs:
  - A bus's address output carries the write address when that bus is writing, else the read address.
  - Otherwise the address output holds its last value.
- dma_hold=1 in RUN: no read is issued. A pending write still completes.
- Strobe gating:
  - All strobes are 0 when ce=0. State, dst_q and wr_v hold.
  - Strobes are 0 in IDLE.
- cpu_halt = dma_en | (state≠IDLE), combinational.
- reset (takes priority over ce):
  - Next edge forces IDLE, wr_v=0, dir_q=0, dst_q=0, xfer_count=0.
  - A pending write is dropped, not performed.

## Timing
- Read issued in ce-cycle N; matching write in ce-cycle N+1 (the next ce=1 cycle). Source-to-destination latency is 1 ce-cycle.
- Read strobe and address are combinational from the inputs and state. Write data is combinational from din; write address comes from the register.
- Throughput is one byte per non-hold ce-cycle. Hold cycles insert bubbles with no read.
- After dma_en falls, exactly one trailing write follows if wr_v=1. cpu_halt drops on the cycle after that write.
- Reset values:
  - all strobes 0
  - cbus_a=0, vbus_a=0, cbus_dout=0, vbus_dout=0
  - cpu_halt=dma_en
  - xfer_count=0
- Address wrap-around is the generator's job. This block passes the address through untouched.

## Configuration
- DMA_XFER_STATS_EN defined:
  - xfer_count increments by 1 on every completed write, wrapping modulo 2^16.
  - It clears on each IDLE→RUN transition.
- Not defined:
  - xfer_count is tied to 0.
  - No counter registers are synthesised.

## Test plan
- CPU→VRAM, 4 bytes, no holds: cbus 0x1000..0x1003 holding AA,BB,CC,DD, vbus 0x0200. Required: VRAM 0x200..0x203 = AA..DD; each write one ce-cycle after its read; cpu_halt high from the dma_en rise until the cycle after the 4th write.
- VRAM→CPU (dma_dir=1), 3 bytes: VRAM 0x1FFE..0x1FFF,0x0000 → cbus 0x2000. Required: the three bytes land at cbus 0x2000..0x2002. dma_dir toggled mid-transfer has no effect.
- dma_hold on the 2nd read cycle: no read that cycle; the 1st byte's write still happens; final memory image identical to the no-hold case.
- ce=1 every 3rd clk: strobes pulse only on ce cycles. The write follows on the next ce, not the next clk.
- reset asserted while wr_v=1: no write occurs; state IDLE, all strobes 0 on the next edge; cpu_halt follows dma_en.
- With DMA_XFER_STATS_EN, 16-byte transfer: xfer_count=16 at end. Next start clears it to 0, then it counts again.
